// File: rtl/sync_fifo_reader_if.sv
// FIFO-read and output-stream signal bundle for sync_fifo_reader.
// The master modport is the reader's view; slave is the FIFO/sink side.
interface sync_fifo_reader_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_r_en;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data_out,
        input  m_ready,
        output fifo_r_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data_out,
        output m_ready,
        input  fifo_r_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/sync_fifo_reader.sv
// Pulls words from a 1-cycle-latency synchronous FIFO into a 2-entry valid/ready output buffer.
// Optional delivered-word counter on rd_count is built when FIFO_RD_CNT_EN is defined.
//
// state    | meaning
// ST_EMPTY | no buffered word, m_valid low
// ST_ONE   | one word buffered in head_q
// ST_TWO   | head_q and tail_q both hold words, head_q is older
module sync_fifo_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    sync_fifo_reader_if.master bus
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CNT_W-1:0]   rd_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    logic              pop;
    logic              capture;
    logic              r_en;
    logic [1:0]        occ;
    logic [2:0]        load;
    logic [2:0]        limit;

    always_comb begin
        occ = 2'd0;
        case (state_q)
            ST_ONE:  occ = 2'd1;
            ST_TWO:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    assign pop     = (state_q != ST_EMPTY) && bus.m_ready;
    assign capture = inflight_q && !flush;

    // Words committed to the buffer (held plus returning) after this cycle's pop must stay below 2.
    assign load  = {1'b0, occ} + {2'b00, inflight_q};
    assign limit = pop ? 3'd3 : 3'd2;
    assign r_en  = !rst && !bus.fifo_empty && !flush && (load < limit);

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = r_en;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (capture) begin
                        head_d  = bus.fifo_data_out;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (capture && pop) begin
                        head_d = bus.fifo_data_out;
                    end else if (capture) begin
                        tail_d  = bus.fifo_data_out;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign bus.fifo_r_en = r_en;
    assign bus.m_valid   = (state_q != ST_EMPTY);
    assign bus.m_data    = head_q;

`ifdef FIFO_RD_CNT_EN
    logic [CNT_W-1:0] rd_count_q, rd_count_d;

    // Counts every accepted transfer; flush does not clear it.
    always_comb begin
        rd_count_d = rd_count_q;
        if (pop) begin
            rd_count_d = rd_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;
`else
    // Counter is not built in this configuration.
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Directed and randomized bench for sync_fifo_reader against a queue-based FIFO/stream model.
// Define FIFO_RD_CNT_EN to also check rd_count (CNT_W=4 so wrap is exercised).
module tb_sync_fifo_reader;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst;
    logic flush;

    sync_fifo_reader_if #(.DATA_W(DATA_W)) ifc();

`ifdef FIFO_RD_CNT_EN
    logic [CNT_W-1:0] rd_count;
`endif

    sync_fifo_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (ifc)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count (rd_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic [CNT_W-1:0] cnt_m = '0;
    int cyc = 0;

    logic       s_ren, s_valid, s_xfer;
    logic [7:0] s_data;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    int         ren_cnt, vcnt, first_ren;
    logic [7:0] dq[$];
    int         dc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] w);
        fq.push_back(w);
        ifc.fifo_empty = 1'b0;
    endtask

    task automatic tick();
        logic [7:0] w;
        #1;
        s_ren   = ifc.fifo_r_en;
        s_valid = ifc.m_valid;
        s_data  = ifc.m_data;
        s_xfer  = s_valid && ifc.m_ready && !rst;
        if (rst || flush || ifc.fifo_empty) chk("ren_blocked", {31'd0, s_ren}, 32'd0);
        if (s_valid && !rst) begin
            chk("valid_has_word", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) chk("head_data", {24'd0, s_data}, {24'd0, exp_q[0]});
        end
        if (prev_hold) begin
            chk("hold_valid", {31'd0, s_valid}, 32'd1);
            chk("hold_data", {24'd0, s_data}, {24'd0, prev_data});
        end
`ifdef FIFO_RD_CNT_EN
        chk("rd_count", {28'd0, rd_count}, {28'd0, cnt_m});
`endif
        prev_hold = s_valid && !ifc.m_ready && !rst && !flush;
        prev_data = s_data;
        if (s_xfer && !flush && exp_q.size() != 0) void'(exp_q.pop_front());
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (rst) cnt_m = '0;
        else if (s_xfer) cnt_m = cnt_m + 1'b1;
        if (rst || flush) exp_q.delete();
        if (s_ren && fq.size() != 0) begin
            w = fq.pop_front();
            ifc.fifo_data_out = w;
            exp_q.push_back(w);
        end
        ifc.fifo_empty = (fq.size() == 0);
    endtask

    task automatic clr_log();
        ren_cnt   = 0;
        vcnt      = 0;
        first_ren = -1;
        dq.delete();
        dc.delete();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (s_ren) begin
                ren_cnt++;
                if (first_ren < 0) first_ren = cyc - 1;
            end
            if (s_valid) vcnt++;
            if (s_xfer) begin
                dq.push_back(s_data);
                dc.push_back(cyc - 1);
            end
        end
    endtask

    initial begin
        rst               = 1'b1;
        flush             = 1'b0;
        ifc.m_ready       = 1'b0;
        ifc.fifo_data_out = '0;
        ifc.fifo_empty    = 1'b1;
        clr_log();
        @(negedge clk);

        // Reset with a non-empty FIFO, then stream 01..08
        for (int i = 1; i <= 8; i++) load(8'(i));
        run(2);
        #1;
        chk("rst_ren", {31'd0, ifc.fifo_r_en}, 32'd0);
        chk("rst_valid", {31'd0, ifc.m_valid}, 32'd0);
        chk("rst_data", {24'd0, ifc.m_data}, 32'd0);
`ifdef FIFO_RD_CNT_EN
        chk("rst_count", {28'd0, rd_count}, 32'd0);
`endif
        rst = 1'b0;
        ifc.m_ready = 1'b1;
        clr_log();
        run(12);
        chk("stream_reads", ren_cnt, 8);
        chk("stream_words", dq.size(), 8);
        if (dq.size() == 8) begin
            chk("stream_latency", dc[0], first_ren + 2);
            for (int i = 0; i < 8; i++) begin
                chk("stream_data", {24'd0, dq[i]}, i + 1);
                chk("stream_gapless", dc[i], dc[0] + i);
            end
        end
`ifdef FIFO_RD_CNT_EN
        #1;
        chk("stream_count", {28'd0, rd_count}, 32'd8);
`endif

        // Backpressure: only two reads, head held, then in-order drain with no gap
        ifc.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(8'hA0 + 8'(i));
        clr_log();
        run(5);
        chk("bp_reads", ren_cnt, 2);
        #1;
        chk("bp_valid", {31'd0, ifc.m_valid}, 32'd1);
        chk("bp_head", {24'd0, ifc.m_data}, 32'hA0);
        chk("bp_ren_low", {31'd0, ifc.fifo_r_en}, 32'd0);
        ifc.m_ready = 1'b1;
        clr_log();
        run(8);
        chk("bp_words", dq.size(), 4);
        if (dq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("bp_data", {24'd0, dq[i]}, 32'hA0 + i);
                chk("bp_gapless", dc[i], dc[0] + i);
            end
        end

        // Single word then empty FIFO
        load(8'h5A);
        clr_log();
        run(6);
        chk("one_reads", ren_cnt, 1);
        chk("one_valid_cycles", vcnt, 1);
        chk("one_words", dq.size(), 1);
        if (dq.size() == 1) chk("one_data", {24'd0, dq[0]}, 32'h5A);

        // Flush with one buffered word and one in flight
        ifc.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(8'h10 + 8'(i));
        clr_log();
        run(3);
        ifc.m_ready = 1'b1;
        clr_log();
        run(1);
        chk("fl_pre_words", dq.size(), 1);
        if (dq.size() == 1) chk("fl_pre_data", {24'd0, dq[0]}, 32'h10);
        chk("fl_pre_read", ren_cnt, 1);
        ifc.m_ready = 1'b0;
        flush = 1'b1;
        run(1);
        flush = 1'b0;
        #1;
        chk("fl_valid_low", {31'd0, ifc.m_valid}, 32'd0);
        ifc.m_ready = 1'b1;
        clr_log();
        run(6);
        chk("fl_words", dq.size(), 1);
        if (dq.size() == 1) chk("fl_next", {24'd0, dq[0]}, 32'h13);

        // Reset overrides flush and drops the in-flight word
        ifc.m_ready = 1'b0;
        load(8'h20);
        load(8'h21);
        run(1);
        rst = 1'b1;
        flush = 1'b1;
        run(1);
        rst = 1'b0;
        flush = 1'b0;
        #1;
        chk("rf_valid_low", {31'd0, ifc.m_valid}, 32'd0);
        ifc.m_ready = 1'b1;
        clr_log();
        run(5);
        chk("rf_words", dq.size(), 1);
        if (dq.size() == 1) chk("rf_data", {24'd0, dq[0]}, 32'h21);

        // 17 transfers from reset on a 4-bit counter
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        for (int i = 0; i < 17; i++) load(8'h30 + 8'(i));
        clr_log();
        run(24);
        chk("wrap_words", dq.size(), 17);
`ifdef FIFO_RD_CNT_EN
        #1;
        chk("wrap_count", {28'd0, rd_count}, 32'd1);
`endif

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(2) == 0 && fq.size() < 12) load(8'($urandom));
            flush = ($urandom_range(29) == 0);
            ifc.m_ready = flush ? 1'b0 : ($urandom_range(3) != 0);
            rst = ($urandom_range(149) == 0);
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        ifc.m_ready = 1'b1;
        run(30);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_fifo_empty", fq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
